// File: rtl/subservient_loader_pkg.sv
// Shared command bytes, state encodings and debug-bus request bundle for the
// subservient UART loader.
package subservient_loader_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_GO    = 8'h47;
    localparam logic [7:0] CMD_HALT  = 8'h48;
    localparam logic [7:0] CMD_READ  = 8'h52;

    // RADDR/RWAIT/TX are only reachable when readback is built in.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_WAIT,
        ST_RADDR,
        ST_RWAIT,
        ST_TX
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        stb;
    } wb_req_t;

endpackage

// File: rtl/subservient_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, half-bit start confirmation and
// centre sampling; emits a one-cycle byte strobe or a framing-error strobe.
module subservient_uart_rx
    import subservient_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_err
);

    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

    logic        rx_meta, rx_sync, rx_prev;
    rx_state_t   state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  sh, sh_n, byte_n;
    logic        vld_n, ferr_n;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            state       <= RX_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            sh          <= '0;
            o_byte      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            rx_meta     <= i_rx;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            sh          <= sh_n;
            o_byte      <= byte_n;
            o_valid     <= vld_n;
            o_frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 16'd1;
        bit_idx_n = bit_idx;
        sh_n      = sh;
        byte_n    = o_byte;
        vld_n     = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_sync) state_n = RX_START;
            end
            RX_START: begin
                // A start that is no longer low at mid-bit was a glitch.
                if (cnt == HALF_END) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_END) begin
                    cnt_n     = '0;
                    sh_n      = {rx_sync, sh[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_END) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    if (rx_sync) begin
                        byte_n = sh;
                        vld_n  = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/subservient_uart_loader.sv
// UART program loader / debug Wishbone master for the subservient SoC.
// Define SUBSERVIENT_LOADER_READBACK_EN to add the 'R' read command and o_tx.
module subservient_uart_loader
    import subservient_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx,
    output logic        o_debug_mode,
    output logic        o_cpu_rst,
    output logic [31:0] o_wb_dbg_adr,
    output logic [31:0] o_wb_dbg_dat,
    output logic [3:0]  o_wb_dbg_sel,
    output logic        o_wb_dbg_we,
    output logic        o_wb_dbg_stb,
    input  logic [31:0] i_wb_dbg_rdt,
    input  logic        i_wb_dbg_ack,
    output logic        o_err
`ifdef SUBSERVIENT_LOADER_READBACK_EN
    ,
    output logic        o_tx
`endif
);

    logic [7:0]  rx_byte;
    logic        rx_vld, rx_ferr;
    ld_state_t   state, state_n;
    wb_req_t     req, req_n;
    logic        debug_mode, debug_mode_n, err_n;
    logic [23:0] asm_q, asm_n;
    logic [1:0]  byte_cnt, byte_cnt_n;
    logic [15:0] len, len_n;

`ifdef SUBSERVIENT_LOADER_READBACK_EN
    localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT - 1);
    logic [9:0]  tx_frame, tx_frame_n;
    logic [23:0] tx_word, tx_word_n;
    logic [3:0]  tx_bits, tx_bits_n;
    logic [1:0]  tx_bytes, tx_bytes_n;
    logic [15:0] tx_cnt, tx_cnt_n;
    logic        tx_q, tx_q_n;
    assign o_tx = tx_q;
`else
    logic unused_rdt;
    assign unused_rdt = ^i_wb_dbg_rdt;
`endif

    subservient_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rx        (i_rx),
        .o_byte      (rx_byte),
        .o_valid     (rx_vld),
        .o_frame_err (rx_ferr)
    );

    assign o_debug_mode = debug_mode;
    assign o_cpu_rst    = debug_mode;
    assign o_wb_dbg_adr = req.adr;
    assign o_wb_dbg_dat = req.dat;
    assign o_wb_dbg_sel = req.sel;
    assign o_wb_dbg_we  = req.we;
    assign o_wb_dbg_stb = req.stb;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            req        <= '0;
            debug_mode <= 1'b1;
            o_err      <= 1'b0;
            asm_q      <= '0;
            byte_cnt   <= '0;
            len        <= '0;
`ifdef SUBSERVIENT_LOADER_READBACK_EN
            tx_frame   <= '1;
            tx_word    <= '0;
            tx_bits    <= '0;
            tx_bytes   <= '0;
            tx_cnt     <= '0;
            tx_q       <= 1'b1;
`endif
        end else begin
            state      <= state_n;
            req        <= req_n;
            debug_mode <= debug_mode_n;
            o_err      <= err_n;
            asm_q      <= asm_n;
            byte_cnt   <= byte_cnt_n;
            len        <= len_n;
`ifdef SUBSERVIENT_LOADER_READBACK_EN
            tx_frame   <= tx_frame_n;
            tx_word    <= tx_word_n;
            tx_bits    <= tx_bits_n;
            tx_bytes   <= tx_bytes_n;
            tx_cnt     <= tx_cnt_n;
            tx_q       <= tx_q_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        req_n        = req;
        debug_mode_n = debug_mode;
        err_n        = rx_ferr;
        asm_n        = asm_q;
        byte_cnt_n   = byte_cnt;
        len_n        = len;
`ifdef SUBSERVIENT_LOADER_READBACK_EN
        tx_frame_n   = tx_frame;
        tx_word_n    = tx_word;
        tx_bits_n    = tx_bits;
        tx_bytes_n   = tx_bytes;
        tx_cnt_n     = tx_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (rx_vld) begin
                    byte_cnt_n = '0;
                    case (rx_byte)
                        CMD_WRITE: if (debug_mode) state_n = ST_ADDR;
                        CMD_GO:    debug_mode_n = 1'b0;
                        CMD_HALT:  debug_mode_n = 1'b1;
`ifdef SUBSERVIENT_LOADER_READBACK_EN
                        CMD_READ:  state_n = ST_RADDR;
`endif
                        default: ;
                    endcase
                end
            end
            ST_ADDR, ST_RADDR: begin
                if (rx_vld) begin
                    asm_n      = {rx_byte, asm_q[23:8]};
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        req_n.adr = {rx_byte, asm_q[23:2], 2'b00};
`ifdef SUBSERVIENT_LOADER_READBACK_EN
                        if (state == ST_RADDR) begin
                            req_n.stb = 1'b1;
                            req_n.we  = 1'b0;
                            req_n.sel = 4'hF;
                            state_n   = ST_RWAIT;
                        end else
`endif
                        state_n = ST_LEN;
                    end
                end
            end
            ST_LEN: begin
                if (rx_vld) begin
                    asm_n      = {rx_byte, asm_q[23:8]};
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd1) begin
                        len_n      = {rx_byte, asm_q[23:16]};
                        byte_cnt_n = '0;
                        state_n    = (len_n == 16'd0) ? ST_IDLE : ST_DATA;
                    end
                end
            end
            ST_DATA, ST_WAIT: begin
                // The next word keeps assembling while the bus write is pending;
                // completing it before the ack is an overrun and restarts it.
                if (rx_vld) begin
                    asm_n      = {rx_byte, asm_q[23:8]};
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        if (req.stb) begin
                            err_n = 1'b1;
                        end else begin
                            req_n.dat = {rx_byte, asm_q};
                            req_n.stb = 1'b1;
                            req_n.we  = 1'b1;
                            req_n.sel = 4'hF;
                            state_n   = ST_WAIT;
                        end
                    end
                end
                if (state == ST_WAIT && req.stb && i_wb_dbg_ack) begin
                    req_n.stb = 1'b0;
                    req_n.we  = 1'b0;
                    req_n.adr = req.adr + 32'd4;
                    len_n     = len - 16'd1;
                    state_n   = (len == 16'd1) ? ST_IDLE : ST_DATA;
                end
            end
`ifdef SUBSERVIENT_LOADER_READBACK_EN
            ST_RWAIT: begin
                if (req.stb && i_wb_dbg_ack) begin
                    req_n.stb  = 1'b0;
                    tx_frame_n = {1'b1, i_wb_dbg_rdt[7:0], 1'b0};
                    tx_word_n  = i_wb_dbg_rdt[31:8];
                    tx_bits_n  = '0;
                    tx_bytes_n = '0;
                    tx_cnt_n   = '0;
                    state_n    = ST_TX;
                end
            end
            ST_TX: begin
                tx_cnt_n = tx_cnt + 16'd1;
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n = '0;
                    if (tx_bits == 4'd9) begin
                        if (tx_bytes == 2'd3) begin
                            state_n = ST_IDLE;
                        end else begin
                            tx_frame_n = {1'b1, tx_word[7:0], 1'b0};
                            tx_word_n  = {8'h00, tx_word[23:8]};
                            tx_bytes_n = tx_bytes + 2'd1;
                            tx_bits_n  = '0;
                        end
                    end else begin
                        tx_frame_n = {1'b1, tx_frame[9:1]};
                        tx_bits_n  = tx_bits + 4'd1;
                    end
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase
`ifdef SUBSERVIENT_LOADER_READBACK_EN
        tx_q_n = (state_n == ST_TX) ? tx_frame_n[0] : 1'b1;
`endif
    end

endmodule

// File: doc/subservient_uart_loader.md
Name: subservient_uart_loader

Overview:
- UART-driven program loader and debug master that sits directly upstream of the subservient SoC's debug Wishbone port.
- Receives a byte-oriented command stream on a serial line and writes 32-bit words into SoC SRAM over the debug interface.
- Owns the debug-mode select and the CPU reset, so firmware can be loaded and the core then released to run.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per UART bit (25 MHz / 115200); legal range 4..65535.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_rx  in  1  UART receive line, asynchronous, idle high.
- o_debug_mode  out  1  drives SoC i_debug_mode.
- o_cpu_rst  out  1  drives SoC i_rst; equals o_debug_mode.
- o_wb_dbg_adr  out  32  debug bus address.
- o_wb_dbg_dat  out  32  debug bus write data.
- o_wb_dbg_sel  out  4  byte enables.
- o_wb_dbg_we  out  1  write enable.
- o_wb_dbg_stb  out  1  strobe.
- i_wb_dbg_rdt  in  32  debug bus read data.
- i_wb_dbg_ack  in  1  debug bus ack.
- o_err  out  1  one-cycle pulse on framing or overrun error.

Behaviour:
- Reset (i_rst_n=0 sampled at an i_clk edge):
  - o_debug_mode=1, o_cpu_rst=1, o_wb_dbg_stb=0, o_wb_dbg_we=0, o_wb_dbg_sel=4'h0, o_wb_dbg_adr=0, o_wb_dbg_dat=0, o_err=0.
  - FSM goes to IDLE.
  - Reset mid-transfer drops stb on the next edge; no ack is awaited.
- RX path:
  - i_rx passes through a 2-flop synchronizer, then 8N1 framing.
  - Start is detected on a high-to-low transition and confirmed at half a bit period; data is sampled at bit centres, LSB first.
  - Stop bit sampled 0: byte discarded, o_err pulses.
  - A byte is valid for exactly one cycle, one cycle after the stop-bit sample.
- Command FSM states: IDLE, ADDR, LEN, DATA, WAIT.
  - IDLE, byte 'W' (0x57) while o_debug_mode=1: go to ADDR.
  - IDLE, byte 'G' (0x47): o_debug_mode=0, o_cpu_rst=0.
  - IDLE, byte 'H' (0x48): o_debug_mode=1, o_cpu_rst=1.
  - IDLE, any other byte, or 'W' while o_debug_mode=0: ignored.
  - ADDR: 4 bytes, little-endian, into the address register. The low 2 bits are forced to 0.
  - LEN: 2 bytes, little-endian word count N. N=0 returns to IDLE with no bus cycles.
  - DATA: collect 4 bytes, little-endian, into the assembly register. On the 4th byte, copy it to o_wb_dbg_dat, set stb=1, we=1, sel=4'hF, and go to WAIT.
  - WAIT: adr/dat/we/sel held stable while stb=1. On the cycle ack=1 is sampled, stb and we drop on the next edge.
    - Address += 4, wrapping modulo 2^32.
    - N decrements; at 0 go to IDLE, else go to DATA.
- Bytes arriving during WAIT are assembled for the next word; the state stays WAIT until the ack.
- Overrun: a 4th byte completes while stb=1. The byte is dropped, o_err pulses, and the partial word restarts.
- ack while stb=0 is ignored.
- 'G' arriving in ADDR/LEN/DATA/WAIT is treated as data, not as a command.

Optional Feature:
- Macro: SUBSERVIENT_LOADER_READBACK_EN.
- With the macro defined:
  - Adds output o_tx (1 bit, reset value 1), an 8N1 transmitter at CLKS_PER_BIT.
  - Adds command 'R' (0x52) followed by 4 address bytes.
  - Issues a read: stb=1, we=0, sel=4'hF.
  - On ack, captures i_wb_dbg_rdt and transmits its 4 bytes little-endian.
  - The FSM returns to IDLE after the last stop bit. RX bytes received during transmission are dropped.
- Without the macro: no o_tx port, and 'R' is ignored in IDLE.

Decomposition:
- Package subservient_loader_pkg holds:
  - Command byte constants: CMD_WRITE, CMD_GO, CMD_HALT, CMD_READ.
  - The FSM state encoding.
- Sub-module subservient_uart_rx: synchronizer, bit timing and framing, producing byte + valid + frame_err.
  - The TX side stays inline.

Test Plan (CLKS_PER_BIT=8):
- Reset then idle line: o_debug_mode=1, o_cpu_rst=1, stb=0 for 100 cycles, o_err never pulses.
- Send 57 00 01 00 00 02 00 EF BE AD DE 78 56 34 12, ack 2 cycles after stb:
  - First write: adr=0x100, dat=0xDEADBEEF.
  - Second write: adr=0x104, dat=0x12345678.
  - Then IDLE.
- Send 47, then 57 00 00 00 00 01 00 ...: o_debug_mode=0 and o_cpu_rst=0 after the 'G' byte; the 'W' is ignored and no stb occurs. Then send 48: o_debug_mode returns to 1.
- Frame with stop bit 0: exactly one o_err pulse and no state change. Separately, hold ack low for 40 bit-times during a 2-word load: overrun o_err pulses, and stb stays high with the first word's dat unchanged.
- Address 0xFFFFFFFC with N=2: writes to 0xFFFFFFFC then 0x00000000. N=0 gives no stb.
- With READBACK_EN: send 52 04 00 00 00 with rdt=0xCAFEF00D at ack → o_tx emits 0D F0 FE CA. Assert reset during WAIT → stb=0 on the next edge.
